// File: rtl/cpu_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | cpu_pkg : constants shared by the core front end                  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package cpu_pkg;
  localparam int          INST_W           = 32;
  localparam int          PC_STEP          = 4;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fetch_unit_if : SRAM, redirect and ID delivery signals of fetch   |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface fetch_unit_if #(
  parameter int DATA_W = 64,
  parameter int INST_W = cpu_pkg::INST_W
);
  logic              enable;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_ren;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [DATA_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    input  enable, imem_rdata, redirect_valid, redirect_pc, inst_ready,
    output imem_addr, imem_ren, inst_valid, inst, inst_pc
  );

  modport slave (
    output enable, imem_rdata, redirect_valid, redirect_pc, inst_ready,
    input  imem_addr, imem_ren, inst_valid, inst, inst_pc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fetch_queue : DEPTH-entry FIFO with sync clear, exposes count     |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module fetch_queue #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  wire              clk,
  input  wire              arst_n,
  input  wire              clear,
  input  wire              push,
  input  wire  [WIDTH-1:0] push_data,
  input  wire              pop,
  output logic [WIDTH-1:0] head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop = pop & (r_count != '0);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push)  r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign count     = r_count;
  assign full      = (r_count == CNT_W'(DEPTH));

  // The issue credit rule must make this unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!arst_n)
    !(push && !clear && full));
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fetch_unit : PC, SRAM issue/credit, redirect and prefetch queue   |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module fetch_unit #(
  parameter int                DATA_W   = 64,
  parameter int                INST_W   = cpu_pkg::INST_W,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(cpu_pkg::RESET_PC_DEFAULT),
  parameter int                PC_STEP  = cpu_pkg::PC_STEP
) (
  input  wire          clk,
  input  wire          arst_n,
  fetch_unit_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int Q_W   = DATA_W + INST_W;

  if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
    $error("fetch_unit: DEPTH must be within 2..16");
  end

  logic [DATA_W-1:0] r_fetch_pc;
  logic [DATA_W-1:0] r_req_pc;
  logic              r_inflight;
  logic [DATA_W-1:0] w_target;
  logic              w_credit;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic [Q_W-1:0]    w_head;

  assign w_target = bus.redirect_pc & ~DATA_W'(3);

  // Occupancy is taken before any pop this cycle, so a read can never
  // return into a full queue.
  assign w_credit = ({1'b0, w_count} + (CNT_W+1)'(r_inflight)) < (CNT_W+1)'(DEPTH);

  // A redirect empties the queue, so its target is issued without credit.
  assign w_issue = bus.redirect_valid ? bus.enable : (bus.enable & w_credit);

  assign bus.imem_ren  = w_issue;
  assign bus.imem_addr = bus.redirect_valid ? w_target : r_fetch_pc;

  assign w_push         = r_inflight & ~bus.redirect_valid;
  assign bus.inst_valid = bus.enable & ~bus.redirect_valid & (w_count != '0);
  assign w_pop          = bus.inst_valid & bus.inst_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_inflight <= bus.enable;
      r_req_pc   <= w_target;
      r_fetch_pc <= bus.enable ? w_target + DATA_W'(PC_STEP) : w_target;
    end else if (w_issue) begin
      r_inflight <= 1'b1;
      r_req_pc   <= r_fetch_pc;
      r_fetch_pc <= r_fetch_pc + DATA_W'(PC_STEP);
    end else begin
      r_inflight <= 1'b0;
    end
  end

  fetch_queue #(
    .WIDTH (Q_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .arst_n    (arst_n),
    .clear     (bus.redirect_valid),
    .push      (w_push),
    .push_data ({r_req_pc, bus.imem_rdata}),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (w_count),
    .full      (w_full)
  );

  assign bus.inst_pc = w_head[Q_W-1:INST_W];
  assign bus.inst    = w_head[INST_W-1:0];
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_fetch_unit : randomized bench against a queue-based fetch model|
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_fetch_unit;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  logic [63:0] m_pc;
  logic [63:0] m_req;
  bit          m_inf;
  ent_t        mq[$];

  fetch_unit_if #(.DATA_W(64), .INST_W(32)) bus();

  fetch_unit #(
    .DATA_W   (64),
    .INST_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (64'h0),
    .PC_STEP  (4)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Memory word k holds the value k.
  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[33:2];
  endfunction

  always @(posedge clk) begin
    if (bus.imem_ren) bus.imem_rdata <= word_of(bus.imem_addr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = 64'h0;
    m_req = 64'h0;
    m_inf = 1'b0;
    mq.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ren"},   64'(bus.imem_ren),   64'h0);
    chk({tag, "_addr"},  bus.imem_addr,       64'h0);
    chk({tag, "_valid"}, 64'(bus.inst_valid), 64'h0);
    chk({tag, "_inst"},  64'(bus.inst),       64'h0);
    chk({tag, "_pc"},    bus.inst_pc,         64'h0);
  endtask

  // One clock: drive inputs, compare against the model, advance the model.
  task automatic step(input bit en, input bit rdy, input bit rv, input logic [63:0] rpc);
    logic [63:0] tgt;
    logic [63:0] exp_addr;
    logic [63:0] exp_inst;
    logic [63:0] exp_ipc;
    bit          exp_ren;
    bit          exp_val;
    bit          pop;
    ent_t        e;
    @(negedge clk);
    bus.enable         = en;
    bus.inst_ready     = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    tgt      = {rpc[63:2], 2'b00};
    exp_ren  = rv ? en : (en && (mq.size() + int'(m_inf) < DEPTH));
    exp_addr = rv ? tgt : m_pc;
    exp_val  = en && !rv && (mq.size() != 0);
    exp_inst = (mq.size() != 0) ? 64'(mq[0].inst) : 64'h0;
    exp_ipc  = (mq.size() != 0) ? mq[0].pc : 64'h0;
    chk("imem_ren",   64'(bus.imem_ren),   64'(exp_ren));
    chk("imem_addr",  bus.imem_addr,       exp_addr);
    chk("inst_valid", 64'(bus.inst_valid), 64'(exp_val));
    chk("inst",       64'(bus.inst),       exp_inst);
    chk("inst_pc",    bus.inst_pc,         exp_ipc);
    pop = exp_val && rdy;
    if (rv) begin
      mq.delete();
      if (en) begin
        m_req = tgt;
        m_pc  = tgt + 64'd4;
        m_inf = 1'b1;
      end else begin
        m_pc  = tgt;
        m_inf = 1'b0;
      end
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_inf) begin
        e.pc   = m_req;
        e.inst = word_of(m_req);
        mq.push_back(e);
      end
      if (exp_ren) begin
        m_req = m_pc;
        m_pc  = m_pc + 64'd4;
        m_inf = 1'b1;
      end else begin
        m_inf = 1'b0;
      end
    end
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2;
    arst_n             = 1'b0;
    bus.enable         = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.enable         = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    arst_n = 1'b1;

    // Streaming from reset
    repeat (20) step(1, 1, 0, 64'h0);
    // ID stall then release
    repeat (10) step(1, 0, 0, 64'h0);
    repeat (8)  step(1, 1, 0, 64'h0);

    // Build 3 queued entries plus one read in flight, then redirect
    for (int i = 0; i < 20; i++) begin
      if (mq.size() == 3 && m_inf) break;
      step(1, 0, 0, 64'h0);
    end
    chk("setup_q3_inflight", 64'((mq.size() == 3) && m_inf), 64'h1);
    step(1, 1, 1, 64'h100);
    repeat (6) step(1, 1, 0, 64'h0);

    // Unaligned target
    step(1, 1, 1, 64'h103);
    repeat (4) step(1, 1, 0, 64'h0);

    // Enable low with a read in flight
    chk("inflight_before_disable", 64'(m_inf), 64'h1);
    repeat (5) step(0, 1, 0, 64'h0);
    repeat (6) step(1, 1, 0, 64'h0);

    // Address wrap-around
    step(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    repeat (6) step(1, 1, 0, 64'h0);

    // Asynchronous reset mid-stream
    reset_mid();
    repeat (10) step(1, 1, 0, 64'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] rpc;
      bit en, rdy, rv;
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) reset_mid();
      step(en, rdy, rv, rpc);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
